// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that shares one external up-counter
// between two requesters. It grants one requester, clears the counter, enables
// it for exactly the latched burst length, and then pulses done for that requester.
`timescale 1ns/1ps

module counter_sched #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic [CNT_W-1:0] cnt_val,
    output logic [1:0]       gnt,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic [1:0]       done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;      // index of the granted requester
    logic [CNT_W-1:0] len_q, len_d;      // burst length latched at grant
    logic             rr_q, rr_d;        // requester that wins a tie next
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             clr_q, clr_d;
    logic             busy_q, busy_d;

    // State register plus registered outputs; reset aborts any burst silently.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            len_q   <= '0;
            rr_q    <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: arbitration in IDLE only, then clear, run, done.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b11) begin
                        sel_d = rr_q;
                    end else begin
                        sel_d = req[1];
                    end
                    len_d   = sel_d ? len1 : len0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // The counter stops at len_q, so equality marks the end of the burst.
                if (cnt_val == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rr_d    = ~sel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so registered outputs line up with it.
    always_comb begin
        gnt_d  = 2'b00;
        done_d = 2'b00;
        clr_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        if ((state_d == S_CLEAR) || (state_d == S_RUN)) begin
            gnt_d = sel_d ? 2'b10 : 2'b01;
        end
        if (state_d == S_CLEAR) begin
            clr_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d = sel_d ? 2'b10 : 2'b01;
        end
    end

    assign gnt     = gnt_q;
    assign cnt_clr = clr_q;
    assign done    = done_q;
    assign busy    = busy_q;

    // Enable is combinational so it drops in the same cycle the count reaches len_q.
    assign cnt_en  = (state_q == S_RUN) && (cnt_val != len_q);

    // Output invariants.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
    a_clr_vs_en  : assert property (@(posedge clk) disable iff (!rst) !(cnt_clr && cnt_en));
    a_done_vs_gnt: assert property (@(posedge clk) disable iff (!rst) !((|done) && (|gnt)));

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a burst-timeline model.
`timescale 1ns/1ps

module tb_counter_sched;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [CNT_W-1:0] len0, len1, cnt_val;
    logic [1:0]       gnt, done;
    logic             cnt_clr, cnt_en, busy;
    logic [CNT_W-1:0] cnt_q = '0;

    int total = 0;
    int bad   = 0;

    counter_sched #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .cnt_val (cnt_val),
        .gnt     (gnt),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Shared external counter driven by the scheduler's clear/enable.
    always @(posedge clk) begin
        if (cnt_clr) cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_val = cnt_q;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req  = 2'b00;
        len0 = '0;
        len1 = '0;
        tick();
        check("reset_outs", {gnt, cnt_clr, cnt_en, done, busy}, 7'd0);
        rst = 1'b1;
        tick();
    endtask

    // Run one burst to completion, dropping each request on its done pulse.
    task automatic run_burst(output logic [1:0] first_gnt, output logic first_clr,
                             output int en_n, output int busy_n,
                             output logic [1:0] done_or, output int done_n);
        bit fin;
        first_gnt = 2'b00;
        first_clr = 1'b0;
        en_n = 0; busy_n = 0; done_or = 2'b00; done_n = 0;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            tick();
            if (i == 0) begin
                first_gnt = gnt;
                first_clr = cnt_clr;
            end
            if (cnt_en) en_n++;
            if (busy) busy_n++;
            if (done != 2'b00) begin
                done_or |= done;
                done_n++;
                req = req & ~done;
            end
            if (!busy) fin = 1'b1;
        end
        check("burst_ends_idle", busy, 1'b0);
    endtask

    typedef struct {
        logic [1:0]       req;
        logic [CNT_W-1:0] l0;
        logic [CNT_W-1:0] l1;
        logic [1:0]       exp_gnt;
        int               exp_en;
        int               exp_busy;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    logic [1:0] gq[$];
    logic [1:0] dq[$];
    int         gaps[$];

    // Reference model state: position within the burst timeline.
    int   m_t, m_len;
    logic m_g, m_rr;

    initial begin : main
        logic [1:0] fg, dor;
        logic       fc, prev_busy, started, found, done_hit;
        logic [1:0] prev_gnt, done_seen;
        logic [6:0] exp_o;
        int         en_n, busy_n, done_n, idle_run, en_pre;

        vecs[0] = '{req:2'b01, l0:4'd3,  l1:4'd9, exp_gnt:2'b01, exp_en:3,  exp_busy:6,  exp_cnt:4'd3};
        vecs[1] = '{req:2'b10, l0:4'd5,  l1:4'd0, exp_gnt:2'b10, exp_en:0,  exp_busy:3,  exp_cnt:4'd0};
        vecs[2] = '{req:2'b01, l0:4'd15, l1:4'd2, exp_gnt:2'b01, exp_en:15, exp_busy:18, exp_cnt:4'd15};
        vecs[3] = '{req:2'b11, l0:4'd2,  l1:4'd5, exp_gnt:2'b01, exp_en:2,  exp_busy:5,  exp_cnt:4'd2};
        vecs[4] = '{req:2'b10, l0:4'd1,  l1:4'd7, exp_gnt:2'b10, exp_en:7,  exp_busy:10, exp_cnt:4'd7};
        vecs[5] = '{req:2'b01, l0:4'd1,  l1:4'd8, exp_gnt:2'b01, exp_en:1,  exp_busy:4,  exp_cnt:4'd1};

        // Directed table: one burst from reset per entry.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            req  = vecs[v].req;
            len0 = vecs[v].l0;
            len1 = vecs[v].l1;
            run_burst(fg, fc, en_n, busy_n, dor, done_n);
            check($sformatf("v%0d_first_gnt", v), fg, vecs[v].exp_gnt);
            check($sformatf("v%0d_first_clr", v), fc, 1'b1);
            check($sformatf("v%0d_en_cycles", v), en_n, vecs[v].exp_en);
            check($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].exp_busy);
            check($sformatf("v%0d_done", v), dor, vecs[v].exp_gnt);
            check($sformatf("v%0d_done_pulses", v), done_n, 1);
            check($sformatf("v%0d_final_cnt", v), cnt_val, vecs[v].exp_cnt);
        end

        // Contention: req=11 held, grants alternate with one idle cycle between.
        do_reset();
        req = 2'b11; len0 = 4'd2; len1 = 4'd5;
        prev_busy = 1'b0; prev_gnt = 2'b00; started = 1'b0; idle_run = 0;
        for (int i = 0; i < 200 && dq.size() < 4; i++) begin
            tick();
            if (gnt != 2'b00 && prev_gnt == 2'b00) gq.push_back(gnt);
            if (done != 2'b00) dq.push_back(done);
            if (busy) begin
                if (started && !prev_busy) gaps.push_back(idle_run);
                started  = 1'b1;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_busy = busy;
            prev_gnt  = gnt;
        end
        req = 2'b00;
        repeat (3) tick();
        check("rr_grant_count", gq.size(), 4);
        check("rr_done_count", dq.size(), 4);
        check("rr_gap_count", gaps.size(), 3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_gnt%0d", k), (k < gq.size()) ? gq[k] : 2'bxx,
                  (k % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_done%0d", k), (k < dq.size()) ? dq[k] : 2'bxx,
                  (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rr_gap%0d", k), (k < gaps.size()) ? gaps[k] : -1, 1);
        end

        // Asynchronous reset while the counter sits at 4, then tie goes to requester 0.
        do_reset();
        req = 2'b01; len0 = 4'd10;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (cnt_val == 4'd4) found = 1'b1;
        end
        check("mid_reached_4", found, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_outs", {gnt, cnt_clr, cnt_en, done, busy}, 7'd0);
        done_hit = 1'b0;
        repeat (3) begin
            tick();
            done_hit = done_hit | (|done);
        end
        check("mid_no_done", done_hit, 1'b0);
        len0 = 4'd1; len1 = 4'd1;
        req  = 2'b11;
        rst  = 1'b1;
        tick();
        check("mid_regrant0", gnt, 2'b01);
        run_burst(fg, fc, en_n, busy_n, dor, done_n);
        check("mid_regrant_done", dor, 2'b01);

        // Length and request changes after grant are ignored.
        do_reset();
        req = 2'b01; len0 = 4'd6; len1 = 4'd3;
        tick();
        check("chg_gnt", gnt, 2'b01);
        en_pre = int'(cnt_en);
        tick();
        en_pre += int'(cnt_en);
        req  = 2'b00;
        len0 = 4'd2;
        run_burst(fg, fc, en_n, busy_n, dor, done_n);
        check("chg_en_cycles", en_pre + en_n, 6);
        check("chg_done", dor, 2'b01);
        check("chg_final_cnt", cnt_val, 4'd6);

        // Randomized traffic against the burst-timeline model.
        do_reset();
        m_t = 0; m_len = 0; m_g = 1'b0; m_rr = 1'b0;
        done_seen = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (done_seen[b]) req[b] = 1'b0;
                else if (!req[b] && $urandom_range(3) == 0) req[b] = 1'b1;
            end
            len0 = CNT_W'($urandom_range(15));
            len1 = CNT_W'($urandom_range(15));
            @(posedge clk);
            // A burst occupies len+3 cycles after grant: clear, len+1 run, done.
            if (m_t == 0) begin
                if (req != 2'b00) begin
                    m_g   = (req == 2'b11) ? m_rr : req[1];
                    m_len = m_g ? int'(len1) : int'(len0);
                    m_t   = 1;
                end
            end else if (m_t == m_len + 3) begin
                m_t  = 0;
                m_rr = ~m_g;
            end else begin
                m_t++;
            end
            #1;
            exp_o = 7'd0;
            if (m_t >= 1 && m_t <= m_len + 2) exp_o[6:5] = m_g ? 2'b10 : 2'b01;
            exp_o[4] = (m_t == 1);
            exp_o[3] = (m_t >= 2) && (m_t - 2 < m_len);
            if (m_t != 0 && m_t == m_len + 3) exp_o[2:1] = m_g ? 2'b10 : 2'b01;
            exp_o[0] = (m_t != 0);
            check($sformatf("rand_cycle%0d", c), {gnt, cnt_clr, cnt_en, done, busy}, exp_o);
            done_seen = done;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
Round-robin scheduler that shares one external free-running-style up-counter (clk/rst/en/clr, width CNT_W) between two requesters. Each requester asks for a counting burst of a given length. The block grants one requester at a time, clears the counter, enables it for exactly the requested number of counts, then signals completion. It sits beside the counter datapath and owns its clear/enable controls.

Parameters:
CNT_W, 4, width of the shared counter, of the burst-length inputs and of the count feedback.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  reset, asynchronous, active-low.
req  in  2  burst request per requester; level, held until the matching done pulse.
len0  in  CNT_W  burst length for requester 0; sampled at grant.
len1  in  CNT_W  burst length for requester 1; sampled at grant.
cnt_val  in  CNT_W  current value of the shared counter.
gnt  out  2  one-hot grant; at most one bit high.
cnt_clr  out  1  synchronous clear to the counter; one-cycle pulse.
cnt_en  out  1  count enable to the counter.
done  out  2  one-cycle completion pulse per requester.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset (rst=0, asynchronous): state=IDLE, gnt=0, cnt_clr=0, done=0, busy=0, len_q=0, rr pointer=0 (requester 0 has priority first). Reset mid-burst aborts the burst silently, with no done pulse.
- Registered outputs: gnt, cnt_clr, done and busy are registered and decoded from state.
- Combinational output: cnt_en = (state==RUN) && (cnt_val != len_q).
- IDLE:
  - If req==0, stay.
  - If exactly one bit is set, grant it.
  - If req==2'b11, grant the requester selected by rr (rr=0 selects requester 0).
  - On grant: latch len_q from the granted requester's len, set the gnt bit, go to CLEAR.
- CLEAR (1 cycle): cnt_clr=1, gnt held, go to RUN.
- RUN:
  - gnt held.
  - cnt_en stays high until cnt_val==len_q. The counter therefore steps 0,1,...,len_q and holds at len_q.
  - In the cycle where cnt_val==len_q: cnt_en=0 and next state is DONE.
  - len_q=0: zero enable cycles; RUN lasts 1 cycle.
- DONE (1 cycle):
  - done[g]=1 for the granted requester; gnt cleared in the same cycle.
  - rr is set to the other requester (g^1).
  - Go to IDLE.
- Latency: req sampled high in IDLE at edge k gives gnt and cnt_clr high after edge k. First cnt_en is after edge k+1. Total busy cycles per burst = len_q + 3.
- Back-to-back: requester re-arbitration happens in IDLE only, so there is a minimum 1 IDLE cycle between bursts.
- req deasserted mid-burst: ignored; the burst completes and done still pulses.
- len changes after grant: ignored, because len_q is latched.
- Boundaries:
  - len=2^CNT_W-1 (15): the counter reaches 15 and stops. The block never relies on counter wrap.
  - A counter that never reaches len_q (external fault) is out of scope; the block stays in RUN.
- Invariants: gnt is one-hot or zero; cnt_clr and cnt_en are never high together; done is never high together with gnt.

Test Plan:
- Single request: reset, req=01, len0=3 → gnt=01 one cycle later; cnt_clr pulse; cnt_en high 3 cycles while cnt_val 0→3; done=01 pulse; busy high 6 cycles; counter holds 3.
- Contention and fairness: req=11 held, len0=2, len1=5 → grant order 0,1,0,1; done alternates 01,10; exactly 1 IDLE cycle between bursts.
- Zero length: req=10, len1=0 → cnt_clr pulse, cnt_en never asserted, done=10 pulse, busy high 3 cycles.
- Max length: req=01, len0=15 → exactly 15 cnt_en cycles; cnt_val ends at 15 with no wrap to 0; done=01.
- Reset mid-burst: req=01, len0=10, assert rst=0 while cnt_val=4 (async, between edges) → all outputs 0 immediately, no done pulse. After release with req=11: requester 0 is granted first.
- Input changes after grant: change len0 from 6 to 2 and drop req during RUN → burst still counts to 6 and done=01 still pulses.
